// File: rtl/mac_rx_frame_buf.sv
// Frame-aware receive FIFO controller in front of a dual-port RAM: speculative
// writes with per-frame commit/rollback, and a registered valid/ready read stream.
module mac_rx_frame_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_eop,
    input  logic                  wr_err,
    output logic [DATA_WIDTH:0]   ram_data,
    output logic                  ram_wren,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH:0]   ram_q,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_eop,
    output logic [ADDR_WIDTH:0]   frame_cnt,
    output logic [15:0]           drop_cnt,
    output logic                  full,
    output logic                  empty
);
    localparam logic [ADDR_WIDTH:0] DEPTH_P = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {W_IDLE, W_FRAME, W_DROP} wstate_t;

    wstate_t               r_state;
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_cm_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_eop;
    logic [ADDR_WIDTH:0]   r_frame_cnt;
    logic [15:0]           r_drop_cnt;

    logic w_full;
    logic w_accept;
    logic w_commit;
    logic w_rollback;
    logic w_load;
    logic w_eop_taken;

    assign w_full      = (r_wr_ptr - r_rd_ptr) == DEPTH_P;
    assign w_accept    = wr_en && !w_full && (r_state != W_DROP);
    assign w_commit    = w_accept && wr_eop && !wr_err;
    // Any EOP that does not commit (error, overflow, or already dropping) rolls back.
    assign w_rollback  = wr_en && wr_eop && !w_commit;
    assign w_load      = (r_cm_ptr != r_rd_ptr) && (!r_rd_valid || rd_ready);
    assign w_eop_taken = r_rd_valid && rd_ready && r_rd_eop;

    // No RAM writes may escape while the controller is held in reset.
    assign ram_wren  = Reset_n && w_accept;
    assign ram_data  = {wr_eop, wr_data};
    assign ram_waddr = r_wr_ptr[ADDR_WIDTH-1:0];
    assign ram_raddr = r_rd_ptr[ADDR_WIDTH-1:0];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= W_IDLE;
            r_wr_ptr   <= '0;
            r_cm_ptr   <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_rollback) begin
                r_wr_ptr <= r_cm_ptr;
                r_state  <= W_IDLE;
                if (r_drop_cnt != 16'hFFFF) begin
                    r_drop_cnt <= r_drop_cnt + 16'd1;
                end
            end else if (w_commit) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_cm_ptr <= r_wr_ptr + 1'b1;
                r_state  <= W_IDLE;
            end else if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_state  <= W_FRAME;
            end else if (wr_en) begin
                r_state  <= W_DROP;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rd_ptr   <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_eop   <= 1'b0;
        end else if (w_load) begin
            {r_rd_eop, r_rd_data} <= ram_q;
            r_rd_valid            <= 1'b1;
            r_rd_ptr              <= r_rd_ptr + 1'b1;
        end else if (rd_ready) begin
            r_rd_valid <= 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_frame_cnt <= '0;
        end else if (w_commit && !w_eop_taken) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end else if (!w_commit && w_eop_taken) begin
            r_frame_cnt <= r_frame_cnt - 1'b1;
        end
    end

    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign rd_eop    = r_rd_eop;
    assign frame_cnt = r_frame_cnt;
    assign drop_cnt  = r_drop_cnt;
    assign full      = w_full;
    assign empty     = (r_cm_ptr == r_rd_ptr) && !r_rd_valid;

endmodule

// File: tb/tb_mac_rx_frame_buf.sv
// Directed bench for mac_rx_frame_buf with a behavioural RAM and a read-side scoreboard.
module tb_mac_rx_frame_buf;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_eop = 1'b0;
    logic          wr_err = 1'b0;
    logic [DW:0]   ram_data;
    logic          ram_wren;
    logic [AW-1:0] ram_waddr;
    logic [AW-1:0] ram_raddr;
    logic [DW:0]   ram_q;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_eop;
    logic [AW:0]   frame_cnt;
    logic [15:0]   drop_cnt;
    logic          full;
    logic          empty;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW:0] mem [0:(1<<AW)-1];
    logic [DW:0] exp_q [$];
    int          peak_fc;
    bit          saw_full;
    int          words_rd;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [DW:0] prev_word  = '0;

    mac_rx_frame_buf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .wr_en(wr_en), .wr_data(wr_data), .wr_eop(wr_eop), .wr_err(wr_err),
        .ram_data(ram_data), .ram_wren(ram_wren), .ram_waddr(ram_waddr),
        .ram_raddr(ram_raddr), .ram_q(ram_q),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_eop(rd_eop),
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .full(full), .empty(empty)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (ram_wren) mem[ram_waddr] <= ram_data;
    end
    assign ram_q = mem[ram_raddr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Read-side monitor: scoreboard every accepted word and check hold under back-pressure.
    always @(negedge Clk) begin
        if (!Reset_n) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                check("hold_valid", rd_valid, 1'b1);
                check("hold_data", {rd_eop, rd_data}, prev_word);
            end
            if (int'(frame_cnt) > peak_fc) peak_fc = int'(frame_cnt);
            if (full) saw_full = 1'b1;
            if (rd_valid && rd_ready) begin
                words_rd++;
                $display("[TB] read word %08h eop %0b", rd_data, rd_eop);
                if (exp_q.size() == 0) begin
                    check("rd_unexpected", 1, 0);
                end else begin
                    check("rd_word", {rd_eop, rd_data}, exp_q.pop_front());
                end
            end
            prev_valid = rd_valid;
            prev_ready = rd_ready;
            prev_word  = {rd_eop, rd_data};
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset_n  = 1'b0;
        wr_en    = 1'b0;
        wr_eop   = 1'b0;
        wr_err   = 1'b0;
        rd_ready = 1'b0;
        tick();
        tick();
        Reset_n  = 1'b1;
        peak_fc  = 0;
        saw_full = 1'b0;
        words_rd = 0;
    endtask

    task automatic write_frame(input int n, input logic [DW-1:0] base, input logic [DW-1:0] step,
                               input logic err, input logic good);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = base + step * DW'(i);
            wr_eop  = (i == n - 1);
            wr_err  = err && (i == n - 1);
            if (good) exp_q.push_back({wr_eop, wr_data});
            tick();
        end
        wr_en  = 1'b0;
        wr_eop = 1'b0;
        wr_err = 1'b0;
    endtask

    task automatic drain(input string tag);
        int cyc;
        cyc = 0;
        while (!(empty && exp_q.size() == 0) && cyc < 300) begin
            tick();
            cyc++;
        end
        check(tag, (cyc >= 300), 1'b0);
    endtask

    initial begin
        int log_fc [$];
        int last_fc;

        do_reset();
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_eop", rd_eop, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_ram_wren", ram_wren, 0);

        // Single frame: latency and ordering
        rd_ready = 1'b1;
        write_frame(4, 32'h11, 32'h11, 1'b0, 1'b1);
        check("t1_valid_at_eop", rd_valid, 0);
        check("t1_fc_commit", frame_cnt, 1);
        tick();
        check("t1_valid_n1", rd_valid, 1);
        check("t1_data_n1", rd_data, 32'h11);
        check("t1_eop_n1", rd_eop, 0);
        tick(); check("t1_data_n2", rd_data, 32'h22);
        tick(); check("t1_data_n3", rd_data, 32'h33);
        tick();
        check("t1_data_n4", rd_data, 32'h44);
        check("t1_eop_n4", rd_eop, 1);
        check("t1_fc_n4", frame_cnt, 1);
        tick();
        check("t1_valid_end", rd_valid, 0);
        check("t1_fc_end", frame_cnt, 0);
        check("t1_empty_end", empty, 1);
        drain("t1_drain");

        // Errored frame is rolled back
        do_reset();
        rd_ready = 1'b1;
        write_frame(3, 32'hA000_0001, 32'h1, 1'b0, 1'b1);
        write_frame(5, 32'hB000_0001, 32'h1, 1'b1, 1'b0);
        check("t2_drop_cnt", drop_cnt, 1);
        check("t2_wr_ptr", ram_waddr, 3);
        drain("t2_drain");
        check("t2_fc_peak", peak_fc, 1);
        check("t2_words", words_rd, 3);

        // Overflow of a 40-word frame into a 32-word RAM
        do_reset();
        for (int i = 0; i < 40; i++) begin
            wr_en   = 1'b1;
            wr_data = 32'hC000_0000 + i;
            wr_eop  = (i == 39);
            #1;
            check("t3_full", full, (i >= 32));
            check("t3_ram_wren", ram_wren, (i < 32));
            tick();
        end
        wr_en  = 1'b0;
        wr_eop = 1'b0;
        #1;
        check("t3_drop_cnt", drop_cnt, 1);
        check("t3_full_after", full, 0);
        check("t3_empty_after", empty, 1);
        check("t3_fc_after", frame_cnt, 0);
        check("t3_wr_ptr", ram_waddr, 0);

        // Back-pressure with rd_ready toggling
        do_reset();
        write_frame(2, 32'hD000_0001, 32'h1, 1'b0, 1'b1);
        write_frame(2, 32'hD000_0011, 32'h1, 1'b0, 1'b1);
        check("t4_fc_two", frame_cnt, 2);
        last_fc = int'(frame_cnt);
        for (int i = 0; i < 30; i++) begin
            rd_ready = ~rd_ready;
            tick();
            if (int'(frame_cnt) != last_fc) begin
                last_fc = int'(frame_cnt);
                log_fc.push_back(last_fc);
            end
        end
        rd_ready = 1'b1;
        drain("t4_drain");
        check("t4_fc_steps", log_fc.size(), 2);
        check("t4_fc_step1", (log_fc.size() > 0) ? log_fc[0] : -1, 1);
        check("t4_fc_step2", (log_fc.size() > 1) ? log_fc[1] : -1, 0);
        check("t4_words", words_rd, 4);

        // Wrap-around: 70 words streamed past the 64-entry pointer range
        do_reset();
        rd_ready = 1'b1;
        for (int f = 0; f < 10; f++) begin
            write_frame(7, 32'hE000_0000 + 32'(f * 16), 32'h1, 1'b0, 1'b1);
        end
        drain("t5_drain");
        check("t5_no_full", saw_full, 0);
        check("t5_words", words_rd, 70);
        check("t5_wr_ptr", ram_waddr, 6);

        // Asynchronous reset in the middle of a frame
        rd_ready = 1'b1;
        wr_en    = 1'b1;
        wr_data  = 32'hF000_0000;
        tick();
        wr_data  = 32'hF000_0001;
        #2;
        Reset_n  = 1'b0;
        #1;
        check("t6_rd_valid", rd_valid, 0);
        check("t6_rd_data", rd_data, 0);
        check("t6_frame_cnt", frame_cnt, 0);
        check("t6_drop_cnt", drop_cnt, 0);
        check("t6_empty", empty, 1);
        check("t6_ram_wren", ram_wren, 0);
        wr_en = 1'b0;
        tick();
        Reset_n  = 1'b1;
        words_rd = 0;
        write_frame(2, 32'h5555_0001, 32'h1, 1'b0, 1'b1);
        drain("t6_drain");
        check("t6_words", words_rd, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
